// File: rtl/cu_sequencer_mod.sv
// Microcode sequencer: selects the next microcode address from the advance
// field of the executing control word, holds the pipeline on data-bus waits,
// and takes the interrupt-entry routine at instruction boundaries.
module cu_sequencer_mod #(
    parameter logic [9:0]  FETCH_ENTRY = 10'h000,
    parameter logic [9:0]  IRQ_ENTRY   = 10'h3F0,
    parameter logic [58:0] NOP_WORD    = 59'h0000_0000_4000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [58:0] ucode_word,
    input  logic [9:0]  dispatch_target,
    input  logic        cond_true,
    input  logic        mem_wait,
    input  logic        irq_req,
    output logic [9:0]  ucode_addr,
    output logic [58:0] control_signals,
    output logic [9:0]  upc,
    output logic        cs_stall,
    output logic        irq_ack
);

    typedef enum logic [1:0] {
        RST_S = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  adv;
    logic        access_active;
    logic        stall;
    logic        irq_take;
    logic [9:0]  next_upc;

    assign adv           = control_signals[29:28];
    // Either strobe low means a bus access is in flight for this word.
    assign access_active = !control_signals[30] || !control_signals[2];

    // Stall detection: mem_wait only matters once a real word is executing.
    always_comb begin
        stall = 1'b0;
        if ((state == RUN || state == STALL) && mem_wait && access_active)
            stall = 1'b1;
    end

    assign cs_stall = stall;

    // Next-address selection; a stall freezes the address on the current word.
    always_comb begin
        next_upc = upc;
        irq_take = 1'b0;
        if (!stall) begin
            unique case (state)
                RST_S: next_upc = FETCH_ENTRY;
                default: begin
                    unique case (adv)
                        2'b00: next_upc = upc + 10'd1;
                        2'b01: next_upc = dispatch_target;
                        2'b10: next_upc = cond_true ? upc + 10'd1 : FETCH_ENTRY;
                        2'b11: begin
                            irq_take = irq_req;
                            next_upc = irq_req ? IRQ_ENTRY : FETCH_ENTRY;
                        end
                    endcase
                end
            endcase
        end
    end

    assign ucode_addr = next_upc;

    // State, control word, upc and interrupt acknowledge registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RST_S;
            control_signals <= NOP_WORD;
            upc             <= 10'h3FF;
            irq_ack         <= 1'b0;
        end else if (stall) begin
            state   <= STALL;
            irq_ack <= 1'b0;
        end else begin
            state           <= RUN;
            control_signals <= ucode_word;
            upc             <= next_upc;
            irq_ack         <= irq_take;
        end
    end

endmodule

// File: tb/tb_cu_sequencer_mod.sv
// Self-checking bench for cu_sequencer_mod: directed scenarios followed by
// randomized stimulus, compared against a behavioural sequencer model.
module tb_cu_sequencer_mod;

    localparam logic [9:0]  FETCH = 10'h000;
    localparam logic [9:0]  IRQE  = 10'h3F0;
    localparam logic [58:0] NOP   = 59'h0000_0000_4000_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic [58:0] ucode_word;
    logic [9:0]  dispatch_target;
    logic        cond_true;
    logic        mem_wait;
    logic        irq_req;
    logic [9:0]  ucode_addr;
    logic [58:0] control_signals;
    logic [9:0]  upc;
    logic        cs_stall;
    logic        irq_ack;

    logic [58:0] rom [1024];

    int tests = 0;
    int fails = 0;

    // Behavioural model: what the sequencer is executing right now.
    bit          m_valid = 1'b0;
    bit          m_in_reset;
    logic [9:0]  m_upc;
    logic [58:0] m_word;
    logic        m_ack;
    logic        e_stall;
    logic [9:0]  e_next;
    logic        e_take;

    always #5 clk = ~clk;

    assign ucode_word = rom[ucode_addr];

    cu_sequencer_mod #(
        .FETCH_ENTRY (FETCH),
        .IRQ_ENTRY   (IRQE),
        .NOP_WORD    (NOP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ucode_word      (ucode_word),
        .dispatch_target (dispatch_target),
        .cond_true       (cond_true),
        .mem_wait        (mem_wait),
        .irq_req         (irq_req),
        .ucode_addr      (ucode_addr),
        .control_signals (control_signals),
        .upc             (upc),
        .cs_stall        (cs_stall),
        .irq_ack         (irq_ack)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [58:0] mkw(input logic [1:0] adv, input logic rd_n, input logic wr_n);
        logic [58:0] w;
        w = {27'($urandom), 32'($urandom)};
        w[29:28] = adv;
        w[30] = rd_n;
        w[2] = wr_n;
        return w;
    endfunction

    // Work out from the rules what the sequencer should do with these inputs.
    task automatic predict();
        logic [1:0] adv;
        adv = m_word[29:28];
        e_take  = 1'b0;
        e_stall = !m_in_reset && mem_wait && (m_word[30] == 1'b0 || m_word[2] == 1'b0);
        if (e_stall)
            e_next = m_upc;
        else if (m_in_reset)
            e_next = FETCH;
        else if (adv == 2'd0)
            e_next = 10'((m_upc + 11'd1) % 11'd1024);
        else if (adv == 2'd1)
            e_next = dispatch_target;
        else if (adv == 2'd2)
            e_next = cond_true ? 10'((m_upc + 11'd1) % 11'd1024) : FETCH;
        else begin
            e_take = irq_req;
            e_next = irq_req ? IRQE : FETCH;
        end
    endtask

    // One clock: apply inputs, check combinational outputs, clock, check registers.
    task automatic step(input logic r, input logic mw, input logic irq,
                        input logic c, input logic [9:0] disp);
        rst = r;
        mem_wait = mw;
        irq_req = irq;
        cond_true = c;
        dispatch_target = disp;
        #1;
        if (m_valid) begin
            predict();
            chk("ucode_addr", 64'(ucode_addr), 64'(e_next));
            chk("cs_stall", 64'(cs_stall), 64'(e_stall));
        end
        @(posedge clk);
        if (r) begin
            m_valid = 1'b1;
            m_in_reset = 1'b1;
            m_upc = 10'h3FF;
            m_word = NOP;
            m_ack = 1'b0;
        end else if (m_valid) begin
            if (e_stall) begin
                m_ack = 1'b0;
            end else begin
                m_ack = e_take;
                m_upc = e_next;
                m_word = rom[e_next];
                m_in_reset = 1'b0;
            end
        end
        @(negedge clk);
        if (m_valid) begin
            chk("upc", 64'(upc), 64'(m_upc));
            chk("control_signals", 64'(control_signals), 64'(m_word));
            chk("irq_ack", 64'(irq_ack), 64'(m_ack));
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_wait = 1'b0;
        irq_req = 1'b0;
        cond_true = 1'b0;
        dispatch_target = '0;
        for (int i = 0; i < 1024; i++) rom[i] = mkw(2'd0, 1'b1, 1'b1);
        rom[10'h000] = mkw(2'd0, 1'b1, 1'b1);
        rom[10'h001] = mkw(2'd1, 1'b1, 1'b1);
        rom[10'h123] = mkw(2'd1, 1'b1, 1'b1);
        rom[10'h050] = mkw(2'd2, 1'b1, 1'b1);
        rom[10'h051] = mkw(2'd3, 1'b0, 1'b1);
        rom[10'h3F0] = mkw(2'd1, 1'b1, 1'b1);
        rom[10'h3FF] = mkw(2'd0, 1'b1, 1'b1);
        @(negedge clk);

        // Reset values
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'h000);
        step(1'b1, 1'b1, 1'b1, 1'b0, 10'h000);
        chk("rst_upc", 64'(upc), 64'h3FF);
        chk("rst_cs", 64'(control_signals), 64'(NOP));
        chk("rst_stall", 64'(cs_stall), 64'h0);
        chk("rst_addr", 64'(ucode_addr), 64'(FETCH));

        // Sequential then dispatch: 0, 1, 123h
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        chk("seq0", 64'(upc), 64'h000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        chk("seq1", 64'(upc), 64'h001);
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h123);
        chk("dispatch", 64'(upc), 64'h123);

        // Conditional at 050h: untaken aborts, taken continues
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h050);
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        chk("cond_false", 64'(upc), 64'h000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h050);
        step(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
        chk("cond_true", 64'(upc), 64'h051);

        // Read word at 051h with end-of-instruction and irq pending: 3 stall cycles
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 10'h000);
            chk("stall_upc", 64'(upc), 64'h051);
            chk("stall_noack", 64'(irq_ack), 64'h0);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 10'h000);
        chk("irq_upc", 64'(upc), 64'(IRQE));
        chk("irq_ack", 64'(irq_ack), 64'h1);

        // Both strobes high: mem_wait ignored; then wrap at 3FFh
        step(1'b0, 1'b1, 1'b0, 1'b0, 10'h3FF);
        chk("nostall_upc", 64'(upc), 64'h3FF);
        chk("ack_pulse", 64'(irq_ack), 64'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
        chk("wrap", 64'(upc), 64'h000);

        // Reset in the middle of a stall
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'h051);
        step(1'b0, 1'b1, 1'b1, 1'b0, 10'h000);
        chk("pre_rst_stall", 64'(cs_stall), 64'h1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 10'h000);
        chk("midstall_rst_cs", 64'(control_signals), 64'(NOP));
        chk("midstall_rst_stall", 64'(cs_stall), 64'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
        chk("restart", 64'(upc), 64'(FETCH));

        // Randomized phase against the model
        for (int i = 0; i < 1024; i++) rom[i] = {27'($urandom), 32'($urandom)};
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
                 1'($urandom), 1'($urandom), 10'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cu_sequencer_mod.md
CU_SEQUENCER_MOD -- requirements
Module: cu_sequencer_mod

Interface
REQ-001 SHALL have parameter FETCH_ENTRY, default 10'h000: microcode address of the opcode-fetch routine.
REQ-002 SHALL have parameter IRQ_ENTRY, default 10'h3F0: microcode address of the interrupt-entry routine.
REQ-003 SHALL have parameter NOP_WORD, default 59'h0000_0000_4000_0004: idle control word, with bits 30 (db_nread) and 2 (db_nwrite) high and all others low.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset, synchronous, active-high.
REQ-006 ucode_word  input  59: microcode ROM data for ucode_addr, combinational read in the same cycle.
REQ-007 dispatch_target  input  10: routine entry address for the current {cb_prefix, opcode}, from the external decode ROM.
REQ-008 cond_true  input  1: the branch condition selected by the current instruction is met.
REQ-009 mem_wait  input  1: data bus is not ready; an access issued this cycle has not completed.
REQ-010 irq_req  input  1: an enabled interrupt is pending.
REQ-011 ucode_addr  output  10: microcode ROM address (next_upc).
REQ-012 control_signals  output  59: registered control word consumed by the control-signal field mapper.
REQ-013 upc  output  10: address of the word currently held in control_signals.
REQ-014 cs_stall  output  1: the current word is being held because of mem_wait.
REQ-015 irq_ack  output  1: one-cycle pulse when the interrupt entry is taken.

Function
REQ-016 SHALL treat adv = control_signals[29:28] as the advance select of the executing word.
REQ-017 SHALL have states RST_S, RUN and STALL, and no others.
REQ-018 SHALL compute next_upc combinationally and drive ucode_addr = next_upc.
REQ-019 On a non-stalled clock edge, SHALL load control_signals <= ucode_word and upc <= next_upc, so word latency is 1 cycle from address to output.
REQ-020 In RST_S, next_upc SHALL be FETCH_ENTRY, and the state SHALL go to RUN on the next edge.
REQ-021 In RUN with adv=00, next_upc SHALL be upc+1, with 10-bit wrap (10'h3FF -> 10'h000).
REQ-022 In RUN with adv=01, next_upc SHALL be dispatch_target, sampled in the same cycle.
REQ-023 In RUN with adv=10, next_upc SHALL be upc+1 if cond_true, otherwise FETCH_ENTRY (abort the untaken conditional).
REQ-024 In RUN with adv=11 (end of instruction), next_upc SHALL be IRQ_ENTRY if irq_req, otherwise FETCH_ENTRY.
REQ-025 The stall condition SHALL be mem_wait high while in RUN or STALL with control_signals[30]==0 or control_signals[2]==0; otherwise mem_wait SHALL be ignored.
REQ-026 While the stall condition holds, cs_stall SHALL be 1 and the state SHALL be STALL.
REQ-027 While stalled, control_signals and upc SHALL hold, and ucode_addr SHALL equal upc.
REQ-028 Stall SHALL override adv decoding, irq_req and cond_true; those inputs SHALL be evaluated only in the cycle the stall clears.
REQ-029 When the stall condition drops, the state SHALL return to RUN and normal adv decoding SHALL apply in that same cycle.
REQ-030 irq_ack SHALL be registered and SHALL be 1 exactly in the cycle after an edge that loaded upc <= IRQ_ENTRY through adv=11; otherwise it SHALL be 0.
REQ-031 irq_req asserted with any adv other than 11 SHALL have no effect.
REQ-032 cs_stall SHALL be combinational from the state, mem_wait and control_signals; all other outputs SHALL be registered or derived from registers plus inputs as stated above.

Reset
REQ-033 On rst=1 at an edge: state=RST_S, control_signals=NOP_WORD, upc=10'h3FF, irq_ack=0.
REQ-034 After reset, cs_stall SHALL be 0 and ucode_addr SHALL be FETCH_ENTRY.
REQ-035 Reset SHALL override stall, dispatch and irq at any point, including mid-instruction and mid-stall.
REQ-036 The first fetched word (address 0) SHALL appear on control_signals one cycle after rst deasserts.

Verification
REQ-037 Reset, then ROM word at 0 with adv=00 and at 1 with adv=01, dispatch_target=10'h123 -> upc sequence 0, 1, 123h on consecutive cycles; ucode_addr leads upc by one cycle.
REQ-038 Word with adv=10 at 10'h050: cond_true=0 -> next upc=000h; cond_true=1 -> next upc=051h.
REQ-039 Word with bit30=0 (read) and mem_wait high for 3 cycles -> control_signals and upc held 3 cycles with cs_stall=1; advances on the 4th cycle. mem_wait high with bits 30 and 2 both set -> no stall.
REQ-040 adv=11 with irq_req=1 -> upc=3F0h and a 1-cycle irq_ack pulse. adv=11 with irq_req=1 and mem_wait stalling an active access -> no ack until the stall clears.
REQ-041 adv=00 at upc=3FFh -> upc wraps to 000h.
REQ-042 rst asserted mid-stall -> control_signals=NOP_WORD, cs_stall=0, then a restart at FETCH_ENTRY.
